fir_frame_driver: RTL and testbench
===================================

FIR_FRAME_DRIVER -- requirements
Module: fir_frame_driver

Interface
REQ-001 Parameter TAPS, default 128, is the number of fir_ready strobes per filter frame; it SHALL be a power of two.
REQ-002 Parameter FIFO_DEPTH, default 8, is the input sample FIFO depth in words; it SHALL be a power of two.
REQ-003 Parameter STROBE_DIV, default 1, sets fir_ready pacing: at most one strobe per STROBE_DIV clk cycles.
REQ-004 Port clk, input, 1 bit: the single clock, rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port s_valid, input, 1 bit: upstream sample valid.
REQ-007 Port s_data, input, 18 bits signed: upstream sample.
REQ-008 Port s_ready, output, 1 bit: FIFO can accept a word.
REQ-009 Port fir_ready, output, 1 bit: single-cycle MAC strobe to the filter.
REQ-010 Port fir_sig, output, 18 bits signed: sample presented to the filter.
REQ-011 Port fir_filtred, input, 18 bits signed: filter result.
REQ-012 Port m_valid, output, 1 bit: filtered result valid.
REQ-013 Port m_data, output, 18 bits signed: filtered result.
REQ-014 Port m_ready, input, 1 bit: downstream accepts the result.
REQ-015 Port busy, output, 1 bit: high while state is RUN.

Function
REQ-016 A word SHALL be pushed into the FIFO on every cycle where s_valid and s_ready are both high; s_ready = not full.
REQ-017 Strobe counter cnt, log2(TAPS) bits, SHALL increment modulo TAPS on every fir_ready pulse and SHALL mirror the filter tap index, with cnt = TAPS-1 after reset.
REQ-018 States: IDLE (cnt = TAPS-1, waiting to load) and RUN (cnt 0..TAPS-2).
REQ-019 IDLE SHALL issue a load strobe only when all three hold: the FIFO is non-empty, the pacing divider has expired, and the result slot is free (m_valid = 0, or m_ready = 1 that cycle).
REQ-020 During a load strobe, fir_sig SHALL equal the FIFO head, and the head SHALL pop on that edge; the transition is IDLE -> RUN.
REQ-021 RUN SHALL issue one strobe per STROBE_DIV cycles unconditionally, independent of FIFO and m_ready.
REQ-022 RUN SHALL return to IDLE on the strobe that makes cnt = TAPS-1.
REQ-023 Pacing divider: fir_ready SHALL be high only when div_cnt = STROBE_DIV-1, and div_cnt SHALL restart at 0 on each strobe.
REQ-024 With STROBE_DIV = 1, the strobe SHALL be continuous in RUN.
REQ-025 Result capture: one cycle after a load strobe, m_data SHALL take fir_filtred and m_valid SHALL rise, except after the first load following reset.
REQ-026 The first load after reset sets a primed flag and produces no output (the filter result from the reset sums is discarded).
REQ-027 m_valid SHALL clear on any m_valid and m_ready handshake that is not coincident with a new capture; m_data SHALL hold while m_valid = 1 and m_ready = 0.
REQ-028 A simultaneous push and pop with the FIFO full SHALL be disallowed (s_ready = 0); with the FIFO empty, a push SHALL NOT be readable in the same cycle.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with occupancy tracked in log2(FIFO_DEPTH)+1 bits.
REQ-030 Steady-state frame period SHALL be TAPS*STROBE_DIV cycles, given a non-empty FIFO and a free result slot.

Reset
REQ-031 rst SHALL force the following immediately and asynchronously: fir_ready = 0, fir_sig = 0, m_valid = 0, m_data = 0, busy = 0, FIFO empty (s_ready = 1), cnt = TAPS-1, div_cnt = 0, primed = 0, state IDLE.
REQ-032 Reset mid-frame SHALL abort the frame and discard FIFO contents and any pending result.
REQ-033 The system SHALL reinitialise the filter whenever rst is asserted.

Structure
REQ-034 A shared package SHALL hold the sample width constant (18), TAPS default, and the state enumeration (IDLE, RUN).
REQ-035 The FIFO SHALL be one sub-module, sample_fifo (width 18, depth FIFO_DEPTH, first-word fall-through head).

Verification
REQ-036 Reset: assert rst mid-cycle -> all outputs 0 and s_ready = 1 without waiting for a clk edge.
REQ-037 STROBE_DIV = 1, push 1000 then 2000: first load at cnt 127, 127 RUN strobes, no m_valid; second load at 128 cycles after the first; m_valid rises the next cycle.
REQ-038 Impulse against the filter model: push 256 followed by 160 zeros, m_ready = 1 -> m_data sequence reproduces the tap set, including two consecutive 50s, and all other outputs are 0.
REQ-039 Backpressure: hold m_ready = 0 with m_valid = 1 and keep pushing -> no load strobe and fir_ready = 0 at cnt 127; FIFO fills to 8 and s_ready = 0; raising m_ready for one cycle -> handshake plus a load strobe that same cycle.
REQ-040 STROBE_DIV = 4 -> fir_ready pulses exactly every 4th cycle in RUN, and frame period = 512 cycles.
REQ-041 Reset at cnt = 60 with 3 words queued -> FIFO empty, cnt = 127, the next push produces a load only, and no m_valid appears for the following frame.

Source files
------------

// File: rtl/fir_frame_driver_pkg.sv
// Shared definitions for the FIR frame driver.
// Holds the sample width, the default tap count and the frame state encoding.
package fir_frame_driver_pkg;

    localparam int unsigned SAMPLE_W     = 18;
    localparam int unsigned TAPS_DEFAULT = 128;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fir_frame_driver_if.sv
// Bus bundle for the FIR frame driver.
//   s_valid/s_data/s_ready    : upstream sample stream into the FIFO
//   fir_ready/fir_sig         : MAC strobe and sample towards the filter
//   fir_filtred               : filter result back from the filter
//   m_valid/m_data/m_ready    : downstream result stream
//   busy                      : frame in progress
// slave is the driver's view, master is the environment's view.
interface fir_frame_driver_if;
    import fir_frame_driver_pkg::*;

    logic    s_valid;
    sample_t s_data;
    logic    s_ready;
    logic    fir_ready;
    sample_t fir_sig;
    sample_t fir_filtred;
    logic    m_valid;
    sample_t m_data;
    logic    m_ready;
    logic    busy;

    modport slave (
        input  s_valid, s_data, fir_filtred, m_ready,
        output s_ready, fir_ready, fir_sig, m_valid, m_data, busy
    );

    modport master (
        output s_valid, s_data, fir_filtred, m_ready,
        input  s_ready, fir_ready, fir_sig, m_valid, m_data, busy
    );

endinterface

// File: rtl/fir_frame_driver_sample_fifo.sv
// sample_fifo: synchronous FIFO with a first-word fall-through head.
//   clk, rst  : clock and asynchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i when not full
//   wdata_i   : write data
//   pop_i     : drop the head when not empty
//   full_o    : no room for another word
//   empty_o   : no word available
//   rdata_o   : current head word (valid while !empty_o)
module sample_fifo
    import fir_frame_driver_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a word is only read after it was written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fir_frame_driver.sv
// fir_frame_driver: feeds a serial FIR filter one frame at a time.
// Each frame starts with a load strobe that hands the FIFO head to the filter,
// followed by TAPS-1 MAC strobes; the previous frame's result is captured on
// the load strobe of the next frame.
//   clk, rst  : clock and asynchronous active-high reset
//   bus       : slave view of fir_frame_driver_if (sample in, filter side,
//               result out, busy)
module fir_frame_driver
    import fir_frame_driver_pkg::*;
#(
    parameter int unsigned TAPS       = TAPS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned STROBE_DIV = 1
) (
    input logic               clk,
    input logic               rst,
    fir_frame_driver_if.slave bus
);

    localparam int unsigned CW = $clog2(TAPS);
    localparam int unsigned DW = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TAPS - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(STROBE_DIV - 1);
    localparam logic [0:0]    ST_IDLE  = IDLE;
    localparam logic [0:0]    ST_RUN   = RUN;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] div_q, div_d;
    logic          primed_q, primed_d;
    logic          m_valid_q, m_valid_d;
    sample_t       m_data_q, m_data_d;

    logic    fifo_full, fifo_empty;
    sample_t fifo_head;
    logic    div_done, slot_free, load, strobe;

    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.s_valid),
        .wdata_i (bus.s_data),
        .pop_i   (load),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .rdata_o (fifo_head)
    );

    assign div_done  = (div_q == DIV_LAST);
    // The result slot is free if empty or being drained this very cycle.
    assign slot_free = !m_valid_q || bus.m_ready;
    assign load      = (state_q == ST_IDLE) && !fifo_empty && div_done && slot_free;
    assign strobe    = (state_q == ST_RUN) ? div_done : load;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        primed_d  = primed_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        // Divider parks at its terminal value while waiting in IDLE.
        if (strobe) begin
            div_d = '0;
        end else if (!div_done) begin
            div_d = div_q + 1'b1;
        end

        if (strobe) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_d == CNT_LAST) ? ST_IDLE : ST_RUN;
        end

        if (m_valid_q && bus.m_ready) m_valid_d = 1'b0;
        // The first load after reset only primes: the filter holds reset sums.
        if (load) begin
            primed_d = 1'b1;
            if (primed_q) begin
                m_valid_d = 1'b1;
                m_data_d  = bus.fir_filtred;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_LAST;
            div_q     <= '0;
            primed_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            primed_q  <= primed_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign bus.s_ready   = !fifo_full;
    assign bus.fir_ready = strobe;
    assign bus.fir_sig   = load ? fifo_head : '0;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.busy      = (state_q == ST_RUN);

endmodule

// File: tb/tb_fir_frame_driver.sv
// Bench for fir_frame_driver: two instances (STROBE_DIV 1 and 4) driven by a
// behavioural model with a queue-based FIFO, frame position counters and a
// reference FIR filter that also supplies fir_filtred.
module tb_fir_frame_driver;
    import fir_frame_driver_pkg::*;

    localparam int T = 128;
    localparam int D = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic    sv [2];
    sample_t sd [2];
    logic    mr [2];
    sample_t ff [2];

    logic    o_sr [2], o_fr [2], o_mv [2], o_busy [2];
    sample_t o_sig [2], o_md [2];

    fir_frame_driver_if bus1 ();
    fir_frame_driver_if bus4 ();

    assign bus1.s_valid     = sv[0];
    assign bus1.s_data      = sd[0];
    assign bus1.m_ready     = mr[0];
    assign bus1.fir_filtred = ff[0];
    assign bus4.s_valid     = sv[1];
    assign bus4.s_data      = sd[1];
    assign bus4.m_ready     = mr[1];
    assign bus4.fir_filtred = ff[1];

    assign o_sr[0]   = bus1.s_ready;
    assign o_fr[0]   = bus1.fir_ready;
    assign o_sig[0]  = bus1.fir_sig;
    assign o_mv[0]   = bus1.m_valid;
    assign o_md[0]   = bus1.m_data;
    assign o_busy[0] = bus1.busy;
    assign o_sr[1]   = bus4.s_ready;
    assign o_fr[1]   = bus4.fir_ready;
    assign o_sig[1]  = bus4.fir_sig;
    assign o_mv[1]   = bus4.m_valid;
    assign o_md[1]   = bus4.m_data;
    assign o_busy[1] = bus4.busy;

    fir_frame_driver #(.TAPS(T), .FIFO_DEPTH(D), .STROBE_DIV(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    fir_frame_driver #(.TAPS(T), .FIFO_DEPTH(D), .STROBE_DIV(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model state
    int mq [2][$];
    int hist [2][$];
    int pos [2], dv [2], md [2], fidx [2], mvcyc [2], strc [2];
    bit prim [2], mv [2];
    bit p_str [2], p_load [2], p_push [2], p_hs [2];
    int p_sig [2], p_pd [2];
    int load_t [2][$], strl [2][$], mvl [2][$], outs [2][$];

    function automatic int tap(input int k);
        if (k == 0) return 16;
        if (k == 63 || k == 64) return 50;
        return ((k * 37 + 11) % 97) - 48;
    endfunction

    function automatic int sdiv(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic sample_t fsum(input int i);
        longint s;
        longint sh;
        s = 0;
        for (int k = 0; k < hist[i].size(); k++) s += longint'(tap(k)) * hist[i][k];
        sh = s >>> 8;
        return sh[17:0];
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s[%0d] at cycle %0d: got %0d, expected %0d", nm, idx, cyc, act, exp);
        end
    endtask

    // One clock: compare at negedge, advance model at posedge, return at posedge+1.
    task automatic cycle();
        bit      div_ok, busy_e, slot, ld, st, sr_e;
        bit      upd [2];
        sample_t nff [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mq[i].delete();
                hist[i].delete();
                pos[i] = T - 1; dv[i] = 0; prim[i] = 0; mv[i] = 0; md[i] = 0;
                fidx[i] = T - 1; ff[i] = '0;
                p_str[i] = 0; p_load[i] = 0; p_push[i] = 0; p_hs[i] = 0;
                chk("rst_s_ready", i, int'(o_sr[i]), 1);
                chk("rst_fir_ready", i, int'(o_fr[i]), 0);
                chk("rst_fir_sig", i, int'(o_sig[i]), 0);
                chk("rst_m_valid", i, int'(o_mv[i]), 0);
                chk("rst_m_data", i, int'(o_md[i]), 0);
                chk("rst_busy", i, int'(o_busy[i]), 0);
            end else begin
                div_ok = (dv[i] == sdiv(i) - 1);
                busy_e = (pos[i] != T - 1);
                slot   = !mv[i] || mr[i];
                ld     = !busy_e && mq[i].size() > 0 && div_ok && slot;
                st     = busy_e ? div_ok : ld;
                sr_e   = mq[i].size() < D;
                p_str[i]  = st;
                p_load[i] = ld;
                p_sig[i]  = ld ? mq[i][0] : 0;
                p_push[i] = sv[i] && sr_e;
                p_pd[i]   = sd[i];
                p_hs[i]   = mv[i] && mr[i];
                if (mv[i]) mvcyc[i]++;
                chk("s_ready", i, int'(o_sr[i]), int'(sr_e));
                chk("fir_ready", i, int'(o_fr[i]), int'(st));
                chk("fir_sig", i, int'(o_sig[i]), p_sig[i]);
                chk("m_valid", i, int'(o_mv[i]), int'(mv[i]));
                chk("m_data", i, int'(o_md[i]), md[i]);
                chk("busy", i, int'(o_busy[i]), int'(busy_e));
            end
        end
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            upd[i] = 0;
            nff[i] = '0;
            if (!rst) begin
                if (p_str[i]) begin
                    strc[i]++;
                    dv[i]  = 0;
                    pos[i] = (pos[i] + 1) % T;
                end else if (dv[i] != sdiv(i) - 1) begin
                    dv[i]++;
                end
                if (p_hs[i]) begin
                    mv[i] = 0;
                    outs[i].push_back(md[i]);
                end
                if (p_load[i]) begin
                    load_t[i].push_back(cyc);
                    strl[i].push_back(strc[i]);
                    mvl[i].push_back(mvcyc[i]);
                    if (prim[i]) begin
                        mv[i] = 1;
                        md[i] = ff[i];
                    end
                    prim[i] = 1;
                    void'(mq[i].pop_front());
                end
                if (p_push[i]) mq[i].push_back(p_pd[i]);
                // Reference filter: result of a frame is ready at its last strobe.
                if (p_str[i]) begin
                    fidx[i] = (fidx[i] + 1) % T;
                    if (p_load[i]) begin
                        hist[i].push_front(p_sig[i]);
                        if (hist[i].size() > T) void'(hist[i].pop_back());
                    end
                    if (fidx[i] == T - 1) begin
                        upd[i] = 1;
                        nff[i] = fsum(i);
                    end
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) if (upd[i]) ff[i] = nff[i];
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            load_t[i].delete(); strl[i].delete(); mvl[i].delete(); outs[i].delete();
            mvcyc[i] = 0; strc[i] = 0;
        end
    endtask

    task automatic wait_loads(input int i, input int n, input int budget);
        int b;
        b = 0;
        while (load_t[i].size() < n && b < budget) begin
            cycle();
            b++;
        end
        if (load_t[i].size() < n) chk("load_timeout", i, load_t[i].size(), n);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        int b;
        for (int i = 0; i < 2; i++) begin
            sv[i] = 1'b0; sd[i] = '0; mr[i] = 1'b1; ff[i] = '0;
        end
        repeat (3) cycle();
        rst = 1'b0;

        // Frame timing: two samples, first load discarded, second captures.
        clear_stats();
        for (int i = 0; i < 2; i++) begin sv[i] = 1'b1; sd[i] = 18'sd1000; end
        cycle();
        for (int i = 0; i < 2; i++) sd[i] = 18'sd2000;
        cycle();
        for (int i = 0; i < 2; i++) sv[i] = 1'b0;
        wait_loads(0, 2, 400);
        chk("mv_after_load2", 0, int'(o_mv[0]), 1);
        chk("md_after_load2", 0, int'(o_md[0]), 62);
        chk("model_md", 0, md[0], 62);
        if (load_t[0].size() >= 2) begin
            chk("period", 0, load_t[0][1] - load_t[0][0], 128);
            chk("strobes_per_frame", 0, strl[0][1] - strl[0][0], 128);
            chk("no_mv_frame1", 0, mvl[0][1], 0);
        end
        wait_loads(1, 2, 1200);
        chk("mv_after_load2", 1, int'(o_mv[1]), 1);
        chk("md_after_load2", 1, int'(o_md[1]), 62);
        if (load_t[1].size() >= 2) begin
            chk("period", 1, load_t[1][1] - load_t[1][0], 512);
            chk("strobes_per_frame", 1, strl[1][1] - strl[1][0], 128);
            chk("no_mv_frame1", 1, mvl[1][1], 0);
        end

        // Asynchronous reset mid-frame, checked before any clock edge.
        repeat (20) cycle();
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("async_s_ready", i, int'(o_sr[i]), 1);
            chk("async_fir_ready", i, int'(o_fr[i]), 0);
            chk("async_fir_sig", i, int'(o_sig[i]), 0);
            chk("async_m_valid", i, int'(o_mv[i]), 0);
            chk("async_m_data", i, int'(o_md[i]), 0);
            chk("async_busy", i, int'(o_busy[i]), 0);
        end
        repeat (2) cycle();
        rst = 1'b0;

        // Impulse response on the STROBE_DIV=1 instance.
        clear_stats();
        for (int k = 0; k < 161; k++) begin
            sv[0] = 1'b1;
            sd[0] = (k == 0) ? 18'sd256 : 18'sd0;
            b = 0;
            do begin
                cycle();
                b++;
            end while (!p_push[0] && b < 300);
        end
        sv[0] = 1'b0;
        b = 0;
        while (outs[0].size() < 160 && b < 3000) begin
            cycle();
            b++;
        end
        chk("impulse_count", 0, outs[0].size(), 160);
        if (outs[0].size() >= 160) begin
            for (int n = 0; n < 160; n++) chk("impulse", n, outs[0][n], (n < T) ? tap(n) : 0);
            chk("impulse_h0", 0, outs[0][0], 16);
            chk("impulse_h63", 63, outs[0][63], 50);
            chk("impulse_h64", 64, outs[0][64], 50);
        end

        // Backpressure: result held, FIFO fills, no new frame.
        do_reset();
        mr[0] = 1'b0;
        sv[0] = 1'b1;
        repeat (450) begin
            sd[0] = sample_t'($urandom_range(0, 4000));
            cycle();
        end
        chk("bp_m_valid", 0, int'(o_mv[0]), 1);
        chk("bp_s_ready", 0, int'(o_sr[0]), 0);
        chk("bp_fir_ready", 0, int'(o_fr[0]), 0);
        chk("bp_busy", 0, int'(o_busy[0]), 0);
        chk("bp_fifo_level", 0, mq[0].size(), 8);
        mr[0] = 1'b1;
        #1;
        chk("bp_release_load", 0, int'(o_fr[0]), 1);
        cycle();
        mr[0] = 1'b0;
        sv[0] = 1'b0;
        #1;
        chk("bp_recapture", 0, int'(o_mv[0]), 1);
        chk("bp_run", 0, int'(o_busy[0]), 1);
        mr[0] = 1'b1;

        // Reset at cnt 60 with three words queued.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            sv[0] = 1'b1;
            sd[0] = sample_t'(100 + k);
            cycle();
        end
        sv[0] = 1'b0;
        b = 0;
        while (pos[0] != 60 && b < 300) begin
            cycle();
            b++;
        end
        chk("reach_cnt60", 0, pos[0], 60);
        chk("queued_at_60", 0, mq[0].size(), 3);
        #2 rst = 1'b1;
        #1;
        chk("r60_s_ready", 0, int'(o_sr[0]), 1);
        chk("r60_busy", 0, int'(o_busy[0]), 0);
        repeat (2) cycle();
        rst = 1'b0;
        clear_stats();
        sv[0] = 1'b1;
        sd[0] = 18'sd777;
        cycle();
        sv[0] = 1'b0;
        repeat (300) cycle();
        chk("r60_loads", 0, load_t[0].size(), 1);
        chk("r60_no_mv", 0, mvcyc[0], 0);

        // Random traffic on both instances.
        do_reset();
        repeat (4000) begin
            for (int i = 0; i < 2; i++) begin
                sv[i] = ($urandom_range(0, 3) != 0);
                sd[i] = sample_t'($urandom);
                mr[i] = ($urandom_range(0, 2) != 0);
            end
            cycle();
        end
        for (int i = 0; i < 2; i++) sv[i] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
